// File: rtl/lowpass.sv
// Direct Form I biquad lowpass, 7 selectable cutoffs plus bypass, one sample per 3 clocks.
// Two shared 16x18 multipliers feed a 38-bit accumulator; the output is rounded, saturated and registered.
module lowpass #(
  parameter int FS   = 48000,
  parameter int CW   = 18,
  parameter int ACCW = 38
) (
  input  logic               clk_144,
  input  logic               reset_n,
  input  logic [2:0]         filter,
  input  logic signed [15:0] highpassIn,
  output logic signed [15:0] highpassOut
);
  localparam int PW = 16 + CW;
  // The coefficient table is only valid at 48 kHz; any other rate falls back to passthrough.
  localparam bit ROM_OK = (FS == 48000);
  localparam logic signed [ACCW-1:0] RND = ACCW'(32768);

  typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2} phase_t;
  phase_t r_phase, w_phase_nxt;

  logic signed [15:0]     r_x0, r_x1, r_x2, r_y1, r_y2;
  logic signed [CW-1:0]   r_b0, r_b1, r_a1, r_a2;
  logic                   r_bypass;
  logic signed [ACCW-1:0] r_acc;

  logic signed [CW-1:0]   w_rom_b0, w_rom_b1, w_rom_a1, w_rom_a2;
  logic signed [15:0]     w_ma_x, w_mb_x;
  logic signed [CW-1:0]   w_ma_c, w_mb_c;
  logic signed [PW-1:0]   w_pa, w_pb;
  logic signed [ACCW-1:0] w_pa_ext, w_pb_ext, w_acc_nxt, w_rnd, w_q;
  logic [ACCW-16:0]       w_top;
  logic signed [15:0]     w_y_sat, w_y;

  always_ff @(posedge clk_144) begin
    if (reset_n) r_phase <= PH0;
    else         r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = PH0;
    case (r_phase)
      PH0:     w_phase_nxt = PH1;
      PH1:     w_phase_nxt = PH2;
      default: w_phase_nxt = PH0;
    endcase
  end

  // RBJ Butterworth (Q=0.7071) coefficients in Q2.16; b2 equals b0 and is not stored.
  always_comb begin
    w_rom_b0 = '0;
    w_rom_b1 = '0;
    w_rom_a1 = '0;
    w_rom_a2 = '0;
    case (filter)
      3'd1: begin w_rom_b0 = CW'(257);   w_rom_b1 = CW'(513);   w_rom_a1 = CW'(-118970); w_rom_a2 = CW'(54461); end
      3'd2: begin w_rom_b0 = CW'(944);   w_rom_b1 = CW'(1888);  w_rom_a1 = CW'(-107020); w_rom_a2 = CW'(45259); end
      3'd3: begin w_rom_b0 = CW'(3243);  w_rom_b1 = CW'(6487);  w_rom_a1 = CW'(-83862);  w_rom_a2 = CW'(31299); end
      3'd4: begin w_rom_b0 = CW'(6398);  w_rom_b1 = CW'(12797); w_rom_a1 = CW'(-61788);  w_rom_a2 = CW'(21845); end
      3'd5: begin w_rom_b0 = CW'(10161); w_rom_b1 = CW'(20323); w_rom_a1 = CW'(-40646);  w_rom_a2 = CW'(15755); end
      3'd6: begin w_rom_b0 = CW'(19195); w_rom_b1 = CW'(38390); w_rom_a1 = CW'(0);       w_rom_a2 = CW'(11244); end
      3'd7: begin w_rom_b0 = CW'(30484); w_rom_b1 = CW'(60968); w_rom_a1 = CW'(40646);   w_rom_a2 = CW'(15755); end
      default: ;
    endcase
  end

  // Phase 0 uses the ROM directly since the latched set only becomes visible next cycle.
  always_comb begin
    w_ma_x = '0;
    w_ma_c = '0;
    w_mb_x = '0;
    w_mb_c = '0;
    case (r_phase)
      PH0: begin w_ma_x = highpassIn; w_ma_c = w_rom_b0; end
      PH1: begin w_ma_x = r_x1; w_ma_c = r_b1; w_mb_x = r_x2; w_mb_c = r_b0; end
      PH2: begin w_ma_x = r_y1; w_ma_c = r_a1; w_mb_x = r_y2; w_mb_c = r_a2; end
      default: ;
    endcase
  end

  assign w_pa     = PW'(w_ma_x) * PW'(w_ma_c);
  assign w_pb     = PW'(w_mb_x) * PW'(w_mb_c);
  assign w_pa_ext = {{(ACCW-PW){w_pa[PW-1]}}, w_pa};
  assign w_pb_ext = {{(ACCW-PW){w_pb[PW-1]}}, w_pb};

  always_comb begin
    w_acc_nxt = w_pa_ext;
    case (r_phase)
      PH0:     w_acc_nxt = w_pa_ext;
      PH1:     w_acc_nxt = r_acc + w_pa_ext + w_pb_ext;
      default: w_acc_nxt = r_acc - w_pa_ext - w_pb_ext;
    endcase
  end

  assign w_rnd   = w_acc_nxt + RND;
  assign w_q     = w_rnd >>> 16;
  assign w_top   = w_q[ACCW-1:15];
  assign w_y_sat = ((&w_top) || !(|w_top)) ? w_q[15:0]
                 : (w_q[ACCW-1] ? 16'sh8000 : 16'sh7fff);
  assign w_y     = r_bypass ? r_x0 : w_y_sat;

  always_ff @(posedge clk_144) begin
    if (reset_n) begin
      r_acc       <= '0;
      r_x0        <= '0;
      r_x1        <= '0;
      r_x2        <= '0;
      r_y1        <= '0;
      r_y2        <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_a1        <= '0;
      r_a2        <= '0;
      r_bypass    <= 1'b0;
      highpassOut <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      case (r_phase)
        PH0: begin
          r_x0     <= highpassIn;
          r_b0     <= w_rom_b0;
          r_b1     <= w_rom_b1;
          r_a1     <= w_rom_a1;
          r_a2     <= w_rom_a2;
          r_bypass <= (filter == 3'd0) || !ROM_OK;
        end
        PH2: begin
          highpassOut <= w_y;
          r_x2        <= r_x1;
          r_x1        <= r_x0;
          r_y2        <= r_y1;
          r_y1        <= w_y;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lowpass.sv
// Bench for lowpass: real-valued coefficient derivation feeding an integer difference-equation model,
// plus step, passband, stopband, bypass, saturation and mid-sample reset scenarios.
module tb_lowpass;
  localparam real PI = 3.14159265358979323846;

  logic               clk_144 = 1'b0;
  logic               reset_n;
  logic [2:0]         filter;
  logic signed [15:0] highpassIn;
  logic signed [15:0] highpassOut;

  int n_vec = 0;
  int n_bad = 0;

  int     fc_tab [8] = '{0, 1000, 2000, 4000, 6000, 8000, 12000, 16000};
  longint cb0 [8];
  longint cb1 [8];
  longint cb2 [8];
  longint ca1 [8];
  longint ca2 [8];
  longint mx1, mx2, my1, my2;
  longint prev_y;

  lowpass dut (
    .clk_144    (clk_144),
    .reset_n    (reset_n),
    .filter     (filter),
    .highpassIn (highpassIn),
    .highpassOut(highpassOut)
  );

  always #5 clk_144 = ~clk_144;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint q16(input real c);
    real s;
    s = c * 65536.0;
    return (s >= 0.0) ? longint'($floor(s + 0.5)) : -longint'($floor(-s + 0.5));
  endfunction

  // y[n] = b0 x[n] + b1 x[n-1] + b2 x[n-2] - a1 y[n-1] - a2 y[n-2], rounded and clamped.
  function automatic longint model_step(input longint x, input int f);
    longint s;
    longint y;
    if (f == 0) begin
      y = x;
    end else begin
      s = cb0[f]*x + cb1[f]*mx1 + cb2[f]*mx2 - ca1[f]*my1 - ca2[f]*my2;
      y = (s + 32768) >>> 16;
      if (y > 32767)       y = 32767;
      else if (y < -32768) y = -32768;
    end
    mx2 = mx1; mx1 = x; my2 = my1; my1 = y;
    return y;
  endfunction

  task automatic model_clear();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0; prev_y = 0;
  endtask

  task automatic apply_reset(input int ncyc);
    reset_n = 1'b1;
    repeat (ncyc) begin
      @(posedge clk_144); #1;
      check("reset_out", highpassOut, 0);
    end
    reset_n = 1'b0;
    model_clear();
  endtask

  // Called #1 after a phase-2 edge (or after reset release), so the next edge is phase 0.
  task automatic do_sample(input longint x, output longint obs);
    longint exp_y;
    highpassIn = 16'(x);
    exp_y = model_step(x, int'(filter));
    repeat (2) begin
      @(posedge clk_144); #1;
      check("hold", highpassOut, prev_y);
    end
    @(posedge clk_144); #1;
    check("sample", highpassOut, exp_y);
    obs    = highpassOut;
    prev_y = exp_y;
  endtask

  initial begin
    longint y, ymax, ymin, amax, x;
    int nout;
    logic signed [15:0] r16;
    real w, al, a0;
    longint stop_pat [3];

    for (int f = 0; f < 8; f++) begin
      cb0[f] = 0; cb1[f] = 0; cb2[f] = 0; ca1[f] = 0; ca2[f] = 0;
      if (f != 0) begin
        w  = 2.0 * PI * real'(fc_tab[f]) / 48000.0;
        al = $sin(w) / (2.0 * 0.7071);
        a0 = 1.0 + al;
        cb0[f] = q16((1.0 - $cos(w)) / 2.0 / a0);
        cb1[f] = q16((1.0 - $cos(w)) / a0);
        cb2[f] = q16((1.0 - $cos(w)) / 2.0 / a0);
        ca1[f] = q16(-2.0 * $cos(w) / a0);
        ca2[f] = q16((1.0 - al) / a0);
      end
    end
    stop_pat[0] = 0; stop_pat[1] = 7094; stop_pat[2] = -7094;

    // Reset held with full-scale input, then first update three clocks after release.
    filter     = 3'd3;
    highpassIn = 16'sd32767;
    apply_reset(2);
    do_sample(32767, y);
    do_sample(-20000, y);

    // DC step settles to the input with bounded Butterworth overshoot.
    apply_reset(1);
    ymax = -100000;
    nout = 0;
    for (int n = 0; n < 60; n++) begin
      do_sample(16384, y);
      if (y > ymax) ymax = y;
      if (n >= 50 && (y < 16382 || y > 16386)) nout++;
    end
    check("dc_settle_outliers", nout, 0);
    // The bilinear-mapped response at fc = fs/12 peaks a little above the analog 4.3%.
    check("dc_overshoot_ok", (ymax >= 16384 && ymax <= 17203) ? 1 : 0, 1);

    // 1 kHz passband sine, measured on the third cycle.
    ymax = -100000;
    ymin = 100000;
    for (int n = 0; n < 144; n++) begin
      x = longint'($floor(32767.0 * $sin(2.0 * PI * real'(n) / 48.0) + 0.5));
      do_sample(x, y);
      if (n >= 96) begin
        if (y > ymax) ymax = y;
        if (y < ymin) ymin = y;
      end
    end
    check("pass_peak_pos", (ymax >= 32112 && ymax <= 32767) ? 1 : 0, 1);
    check("pass_peak_neg", (ymin <= -32112) ? 1 : 0, 1);

    // 16 kHz stopband tone.
    amax = 0;
    for (int n = 0; n < 60; n++) begin
      do_sample(stop_pat[n % 3], y);
      if (n >= 30 && (y > amax || -y > amax)) amax = (y < 0) ? -y : y;
    end
    check("stop_peak_ok", (amax <= 600) ? 1 : 0, 1);

    // Bypass: output reproduces each sample exactly.
    filter = 3'd0;
    for (int n = 0; n < 30; n++) begin
      r16 = 16'($urandom);
      do_sample(longint'(r16), y);
      check("bypass_eq_in", y, longint'(r16));
    end

    // Every cutoff with random full-range samples.
    for (int f = 1; f < 8; f++) begin
      filter = 3'(f);
      for (int n = 0; n < 20; n++) begin
        r16 = 16'($urandom);
        do_sample(longint'(r16), y);
      end
    end

    // Filter changes on arbitrary samples without clearing state.
    for (int n = 0; n < 40; n++) begin
      filter = 3'($urandom_range(0, 7));
      r16 = 16'($urandom);
      do_sample(longint'(r16), y);
    end

    // Full-scale square at the widest cutoff drives the output into saturation.
    filter = 3'd7;
    for (int n = 0; n < 48; n++) begin
      x = (((n / 4) % 2) == 0) ? 32767 : -32767;
      do_sample(x, y);
    end
    check("pre_midrst_nonzero", (y != 0) ? 1 : 0, 1);

    // Reset lands mid-sample: output clears on the next edge and the run restarts cleanly.
    highpassIn = 16'sd32767;
    @(posedge clk_144); #1;
    reset_n = 1'b1;
    @(posedge clk_144); #1;
    check("midrst_out", highpassOut, 0);
    @(posedge clk_144); #1;
    check("midrst_hold", highpassOut, 0);
    reset_n = 1'b0;
    model_clear();
    for (int n = 0; n < 24; n++) begin
      x = (((n / 4) % 2) == 0) ? 32767 : -32767;
      do_sample(x, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
